// File: rtl/param_fifo_if.sv
// Streaming FIFO bus: control/data in from the producer side,
// data and occupancy status back out.
interface param_fifo_if #(
    parameter int DATA_WIDTH = 9,
    parameter int ADDR_WIDTH = 4
);
    logic                  Clear;
    logic [DATA_WIDTH-1:0] DataIn;
    logic                  Write;
    logic                  Read;
    logic                  ClearOV;
    logic                  ClearUF;
    logic [DATA_WIDTH-1:0] DataOut;
    logic [ADDR_WIDTH:0]   Count;
    logic                  Full;
    logic                  Empty;
    logic                  AlmostFull;
    logic                  AlmostEmpty;
    logic                  OV;
    logic                  UF;

    modport master (
        output Clear, DataIn, Write, Read, ClearOV, ClearUF,
        input  DataOut, Count, Full, Empty,
        input  AlmostFull, AlmostEmpty, OV, UF
    );

    modport slave (
        input  Clear, DataIn, Write, Read, ClearOV, ClearUF,
        output DataOut, Count, Full, Empty,
        output AlmostFull, AlmostEmpty, OV, UF
    );
endinterface

// File: rtl/param_fifo.sv
// Parametrised single-clock FIFO with thresholds, sticky OV/UF,
// synchronous flush and optional first-word-fall-through read.
module param_fifo #(
    parameter int DATA_WIDTH = 9,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = 12,
    parameter int AE_LEVEL   = 4,
    parameter bit FWFT       = 1'b0
) (
    input logic         Clock,
    input logic         Reset,
    param_fifo_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_CNT =
        {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] AF_CNT = AF_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_CNT = AE_LEVEL[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   count_nxt;
    logic                  ov;
    logic                  uf;
    logic                  full;
    logic                  empty;
    logic                  rd_raw;
    logic                  rd_ok;
    logic                  wr_ok;
    logic                  ov_set;
    logic                  uf_set;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // A full FIFO still takes a write when a read frees a slot
    assign rd_raw = bus.Read && !empty;
    assign rd_ok  = rd_raw && !bus.Clear;
    assign wr_ok  = bus.Write && (!full || rd_raw) && !bus.Clear;
    assign ov_set = bus.Write && full && !rd_raw;
    assign uf_set = bus.Read && empty;

    always_comb begin
        count_nxt = count;
        unique case (1'b1)
            wr_ok && !rd_ok: count_nxt = count + 1'b1;
            rd_ok && !wr_ok: count_nxt = count - 1'b1;
            default:         count_nxt = count;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (bus.Clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (rd_ok)
                rd_ptr <= rd_ptr + 1'b1;
            if (wr_ok)
                wr_ptr <= wr_ptr + 1'b1;
            count <= count_nxt;
        end
    end

    // Set beats clear on both sticky flags
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ov <= 1'b0;
            uf <= 1'b0;
        end else if (bus.Clear) begin
            ov <= 1'b0;
            uf <= 1'b0;
        end else begin
            if (ov_set)
                ov <= 1'b1;
            else if (bus.ClearOV)
                ov <= 1'b0;
            if (uf_set)
                uf <= 1'b1;
            else if (bus.ClearUF)
                uf <= 1'b0;
        end
    end

    // Storage is deliberately left out of reset
    always_ff @(posedge Clock) begin
        if (wr_ok)
            mem[wr_ptr] <= bus.DataIn;
    end

    generate
        if (FWFT) begin : g_fwft
            always_comb begin
                bus.DataOut = '0;
                if (!empty)
                    bus.DataOut = mem[rd_ptr];
            end
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] dout;

            always_ff @(posedge Clock or posedge Reset) begin
                if (Reset)
                    dout <= '0;
                else if (bus.Clear)
                    dout <= '0;
                else if (rd_ok)
                    dout <= mem[rd_ptr];
            end

            assign bus.DataOut = dout;
        end
    endgenerate

    assign bus.Count       = count;
    assign bus.Full        = full;
    assign bus.Empty       = empty;
    assign bus.AlmostFull  = (count >= AF_CNT);
    assign bus.AlmostEmpty = (count <= AE_CNT);
    assign bus.OV          = ov;
    assign bus.UF          = uf;
endmodule

// File: tb/tb_param_fifo.sv
// Drives a registered-read and an FWFT FIFO with identical stimulus
// and checks both against a queue-based reference model.
module tb_param_fifo;
    localparam int DW    = 9;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic Clock;
    logic Reset;

    param_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) f0 ();
    param_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) f1 ();

    param_fifo #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(1'b0)
    ) u0 (
        .Clock(Clock), .Reset(Reset), .bus(f0.slave)
    );

    param_fifo #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(1'b1)
    ) u1 (
        .Clock(Clock), .Reset(Reset), .bus(f1.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] q[$];
    logic          mov;
    logic          muf;
    logic [DW-1:0] mdout;

    function automatic void model_reset();
        q.delete();
        mov   = 1'b0;
        muf   = 1'b0;
        mdout = '0;
    endfunction

    function automatic logic [10:0] exp_st();
        int n;
        n = q.size();
        return {5'(n), n == DEPTH, n == 0, n >= 12, n <= 4, mov, muf};
    endfunction

    function automatic logic [DW-1:0] exp_d1();
        if (q.size() == 0)
            return '0;
        return q[0];
    endfunction

    function automatic logic [10:0] st0();
        return {f0.Count, f0.Full, f0.Empty, f0.AlmostFull,
                f0.AlmostEmpty, f0.OV, f0.UF};
    endfunction

    function automatic logic [10:0] st1();
        return {f1.Count, f1.Full, f1.Empty, f1.AlmostFull,
                f1.AlmostEmpty, f1.OV, f1.UF};
    endfunction

    function automatic logic [DW-1:0] rnd_word();
        logic [DW-1:0] d;
        d = DW'($urandom_range(0, 511));
        if (d == 9'h1AA)
            d = 9'h000;
        return d;
    endfunction

    task automatic tick(input logic clr, input logic w,
                        input logic r, input logic [DW-1:0] d,
                        input logic cov, input logic cuf);
        bit rdok;
        bit wrok;
        f0.Clear = clr; f0.Write = w; f0.Read = r;
        f0.DataIn = d; f0.ClearOV = cov; f0.ClearUF = cuf;
        f1.Clear = clr; f1.Write = w; f1.Read = r;
        f1.DataIn = d; f1.ClearOV = cov; f1.ClearUF = cuf;
        @(posedge Clock);
        if (clr) begin
            model_reset();
        end else begin
            rdok = r && (q.size() > 0);
            wrok = w && ((q.size() < DEPTH) || rdok);
            if (rdok)
                mdout = q.pop_front();
            if (wrok)
                q.push_back(d);
            if (w && !wrok)
                mov = 1'b1;
            else if (cov)
                mov = 1'b0;
            if (r && !rdok)
                muf = 1'b1;
            else if (cuf)
                muf = 1'b0;
        end
        #1;
        f0.Clear = 0; f0.Write = 0; f0.Read = 0;
        f0.ClearOV = 0; f0.ClearUF = 0;
        f1.Clear = 0; f1.Write = 0; f1.Read = 0;
        f1.ClearOV = 0; f1.ClearUF = 0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        #2;
        model_reset();
        checks++;
        if (st0() !== 11'b00000_010100) begin
            errors++;
            $display("FAIL reset_st0 got=%b exp=%b", st0(), 11'b00000_010100);
        end
        checks++;
        if (st1() !== exp_st()) begin
            errors++;
            $display("FAIL reset_st1 got=%b exp=%b", st1(), exp_st());
        end
        checks++;
        if (f0.DataOut !== 9'h000 || f1.DataOut !== 9'h000) begin
            errors++;
            $display("FAIL reset_dout got=%h/%h exp=000",
                     f0.DataOut, f1.DataOut);
        end
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 16; i++) begin
            tick(0, 1, 0, DW'(i), 0, 0);
            checks++;
            if (f0.Count !== 5'(i) || f0.AlmostFull !== (i >= 12)) begin
                errors++;
                $display("FAIL fill_%0d got cnt=%0d af=%b exp cnt=%0d af=%b",
                         i, f0.Count, f0.AlmostFull, i, i >= 12);
            end
            checks++;
            if (f1.DataOut !== 9'h001) begin
                errors++;
                $display("FAIL fill_fwft_head got=%h exp=001", f1.DataOut);
            end
        end
        checks++;
        if (f0.Full !== 1'b1 || st1() !== exp_st()) begin
            errors++;
            $display("FAIL fill_full got full=%b st1=%b exp st1=%b",
                     f0.Full, st1(), exp_st());
        end
        for (int i = 1; i <= 16; i++) begin
            tick(0, 0, 1, '0, 0, 0);
            checks++;
            if (f0.DataOut !== DW'(i)) begin
                errors++;
                $display("FAIL drain_%0d got=%h exp=%h", i, f0.DataOut, DW'(i));
            end
            checks++;
            if (f1.DataOut !== exp_d1()) begin
                errors++;
                $display("FAIL drain_fwft_%0d got=%h exp=%h",
                         i, f1.DataOut, exp_d1());
            end
        end
        checks++;
        if (f0.Empty !== 1'b1 || f1.Empty !== 1'b1) begin
            errors++;
            $display("FAIL drain_empty got=%b/%b exp=1", f0.Empty, f1.Empty);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++)
            tick(0, 1, 0, rnd_word(), 0, 0);
        tick(0, 1, 0, 9'h1AA, 0, 0);
        checks++;
        if (f0.OV !== 1'b1 || f1.OV !== 1'b1 || f0.Count !== 5'd16) begin
            errors++;
            $display("FAIL ov_set got ov=%b/%b cnt=%0d exp ov=1 cnt=16",
                     f0.OV, f1.OV, f0.Count);
        end
        tick(0, 1, 0, 9'h1AA, 1, 0);
        checks++;
        if (f0.OV !== 1'b1 || f1.OV !== 1'b1) begin
            errors++;
            $display("FAIL ov_set_wins got=%b/%b exp=1", f0.OV, f1.OV);
        end
        for (int i = 0; i < 16; i++) begin
            tick(0, 0, 1, '0, 0, 0);
            checks++;
            if (f0.DataOut !== mdout || f0.DataOut === 9'h1AA) begin
                errors++;
                $display("FAIL ov_read_%0d got=%h exp=%h", i, f0.DataOut, mdout);
            end
        end
        tick(0, 0, 0, '0, 1, 0);
        checks++;
        if (f0.OV !== 1'b0 || f1.OV !== 1'b0 || st0() !== exp_st()) begin
            errors++;
            $display("FAIL ov_clear got ov=%b/%b st=%b exp ov=0 st=%b",
                     f0.OV, f1.OV, st0(), exp_st());
        end
    endtask

    task automatic test_full_rw();
        for (int i = 0; i < 16; i++)
            tick(0, 1, 0, DW'(9'h040 + i), 0, 0);
        tick(0, 1, 1, 9'h155, 0, 0);
        checks++;
        if (f0.Count !== 5'd16 || f0.OV !== 1'b0 || f0.DataOut !== 9'h040) begin
            errors++;
            $display("FAIL full_rw got cnt=%0d ov=%b d=%h exp cnt=16 ov=0 d=040",
                     f0.Count, f0.OV, f0.DataOut);
        end
        for (int i = 0; i < 16; i++) begin
            tick(0, 0, 1, '0, 0, 0);
            checks++;
            if (f0.DataOut !== ((i == 15) ? 9'h155 : DW'(9'h041 + i))) begin
                errors++;
                $display("FAIL full_rw_read_%0d got=%h exp=%h", i, f0.DataOut,
                         (i == 15) ? 9'h155 : DW'(9'h041 + i));
            end
        end
    endtask

    task automatic test_underflow();
        logic [DW-1:0] prev;
        prev = f0.DataOut;
        tick(0, 0, 1, '0, 0, 0);
        checks++;
        if (f0.UF !== 1'b1 || f1.UF !== 1'b1 || f0.Count !== 5'd0
            || f0.DataOut !== prev || f1.DataOut !== 9'h000) begin
            errors++;
            $display("FAIL uf_set got uf=%b/%b cnt=%0d d=%h/%h exp d=%h/000",
                     f0.UF, f1.UF, f0.Count, f0.DataOut, f1.DataOut, prev);
        end
        tick(0, 1, 1, 9'h0F0, 0, 0);
        checks++;
        if (f0.Count !== 5'd1 || f0.UF !== 1'b1 || f0.DataOut !== prev
            || f1.DataOut !== 9'h0F0) begin
            errors++;
            $display("FAIL uf_wr_rd got cnt=%0d uf=%b d=%h/%h exp 1 1 %h/0f0",
                     f0.Count, f0.UF, f0.DataOut, f1.DataOut, prev);
        end
        tick(0, 0, 1, '0, 0, 1);
        checks++;
        if (f0.UF !== 1'b0 || f0.DataOut !== 9'h0F0 || st1() !== exp_st()) begin
            errors++;
            $display("FAIL uf_clear got uf=%b d=%h st1=%b exp uf=0 d=0f0 st1=%b",
                     f0.UF, f0.DataOut, st1(), exp_st());
        end
        tick(0, 0, 1, '0, 0, 1);
        checks++;
        if (f0.UF !== 1'b1 || f1.UF !== 1'b1) begin
            errors++;
            $display("FAIL uf_set_wins got=%b/%b exp=1", f0.UF, f1.UF);
        end
        tick(0, 0, 0, '0, 0, 1);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++)
            tick(0, 1, 0, rnd_word(), 0, 0);
        for (int i = 0; i < 40; i++) begin
            tick(0, 1, 1, rnd_word(), 0, 0);
            checks++;
            if (f0.DataOut !== mdout || f1.DataOut !== exp_d1()
                || f0.Count !== 5'd3 || f0.AlmostEmpty !== 1'b1) begin
                errors++;
                $display("FAIL wrap_%0d got d=%h/%h cnt=%0d ae=%b exp d=%h/%h",
                         i, f0.DataOut, f1.DataOut, f0.Count,
                         f0.AlmostEmpty, mdout, exp_d1());
            end
        end
        for (int i = 0; i < 3; i++)
            tick(0, 0, 1, '0, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            tick($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 2) != 0 && q.size() > 8
                     || $urandom_range(0, 1) == 1,
                 rnd_word(), $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0);
            checks++;
            if (st0() !== exp_st() || st1() !== exp_st()
                || f0.DataOut !== mdout || f1.DataOut !== exp_d1()) begin
                errors++;
                $display("FAIL rand_%0d got st=%b/%b d=%h/%h exp st=%b d=%h/%h",
                         i, st0(), st1(), f0.DataOut, f1.DataOut,
                         exp_st(), mdout, exp_d1());
            end
        end
    endtask

    task automatic test_fwft_clear_reset();
        tick(1, 0, 0, '0, 0, 0);
        tick(0, 0, 1, '0, 0, 0);
        tick(0, 1, 0, 9'h123, 0, 0);
        checks++;
        if (f1.DataOut !== 9'h123 || f1.Count !== 5'd1) begin
            errors++;
            $display("FAIL fwft_first got d=%h cnt=%0d exp d=123 cnt=1",
                     f1.DataOut, f1.Count);
        end
        for (int i = 0; i < 6; i++)
            tick(0, 1, 0, rnd_word(), 0, 0);
        checks++;
        if (f1.Count !== 5'd7 || f1.UF !== 1'b1 || f1.DataOut !== 9'h123) begin
            errors++;
            $display("FAIL fwft_pre_clear got cnt=%0d uf=%b d=%h exp 7 1 123",
                     f1.Count, f1.UF, f1.DataOut);
        end
        tick(1, 1, 1, 9'h0AA, 0, 0);
        checks++;
        if (st0() !== 11'b00000_010100 || st1() !== 11'b00000_010100
            || f0.DataOut !== 9'h000 || f1.DataOut !== 9'h000) begin
            errors++;
            $display("FAIL clear got st=%b/%b d=%h/%h exp st=00000010100 d=0",
                     st0(), st1(), f0.DataOut, f1.DataOut);
        end
        for (int i = 0; i < 5; i++)
            tick(0, 1, i > 2, rnd_word(), 0, 0);
        tick(0, 1, 1, rnd_word(), 0, 0);
        Reset = 1'b1;
        #1;
        model_reset();
        checks++;
        if (st0() !== exp_st() || st1() !== exp_st()
            || f0.DataOut !== 9'h000 || f1.DataOut !== 9'h000) begin
            errors++;
            $display("FAIL async_reset got st=%b/%b d=%h/%h exp st=%b d=0",
                     st0(), st1(), f0.DataOut, f1.DataOut, exp_st());
        end
        #1;
        Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        f0.Clear = 0; f0.Write = 0; f0.Read = 0;
        f0.DataIn = '0; f0.ClearOV = 0; f0.ClearUF = 0;
        f1.Clear = 0; f1.Write = 0; f1.Read = 0;
        f1.DataIn = '0; f1.ClearOV = 0; f1.ClearUF = 0;
        model_reset();
        test_reset();
        test_fill_drain();
        test_overflow();
        test_full_rw();
        test_underflow();
        test_wrap();
        test_random();
        test_fwft_clear_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/param_fifo.md
Name: param_fifo

Overview:
- Parametrised synchronous FIFO for UART TX/RX buffering and other SoC streaming paths; successor to the fixed 16x9 UART FIFO.
- Width and depth are generic. Adds programmable almost-full/almost-empty thresholds, an occupancy count, sticky overflow and underflow flags, a synchronous flush, and an optional first-word-fall-through (FWFT) read mode.
- Single clock domain; read and write may occur in the same cycle.

Parameters:
- DATA_WIDTH, 9, word width in bits.
- ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH (default 16).
- AF_LEVEL, 12, AlmostFull asserted when Count >= AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 4, AlmostEmpty asserted when Count <= AE_LEVEL; legal range 0..DEPTH-1.
- FWFT, 0, 0 = registered read (1-cycle latency); 1 = head word presented on DataOut without a Read.

Ports:
- Clock  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Clear  in  1  synchronous flush, active-high.
- DataIn  in  DATA_WIDTH  write data.
- Write  in  1  write request.
- Read  in  1  read request.
- ClearOV  in  1  clears sticky OV.
- ClearUF  in  1  clears sticky UF.
- DataOut  out  DATA_WIDTH  read data.
- Count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- Full  out  1  Count == DEPTH.
- Empty  out  1  Count == 0.
- AlmostFull  out  1  Count >= AF_LEVEL.
- AlmostEmpty  out  1  Count <= AE_LEVEL.
- OV  out  1  sticky; a write was dropped.
- UF  out  1  sticky; a read was refused.

Behaviour:
- Reset (asynchronous, any time including mid-transfer):
  - ReadPtr, WritePtr, Count, OV, UF and registered DataOut go to 0.
  - Result: Empty=1, AlmostEmpty=1, Full=0, AlmostFull=0.
  - Storage contents are not reset.
- Clear (synchronous) has the same effect as Reset at the next edge. It overrides Read, Write, ClearOV and ClearUF in that cycle.
- Read acceptance:
  - rd_ok = Read && !Empty.
  - On each accepted read, ReadPtr increments modulo DEPTH; wrap is natural binary rollover of the ADDR_WIDTH-bit pointer.
- Write acceptance:
  - wr_ok = Write && (!Full || rd_ok).
  - A write while Full is accepted if a read is accepted in the same cycle; the freed slot is reused.
  - On each accepted write, mem[WritePtr] <= DataIn and WritePtr increments modulo DEPTH.
- Count update:
  - +1 on wr_ok only.
  - -1 on rd_ok only.
  - Unchanged when both or neither occur.
  - Count never exceeds DEPTH and never goes below 0.
- Write and read in the same cycle while Empty: the write is accepted, the read is refused (UF sets). The new word is readable from the next cycle.
- Flags:
  - Full, Empty, AlmostFull and AlmostEmpty are combinational decodes of the registered Count.
  - Each reflects an accepted operation on the cycle after the edge.
- OV:
  - Sets at the edge where Write && Full && !rd_ok.
  - Stays set until ClearOV or Clear/Reset.
  - If set and ClearOV occur in the same cycle, set wins.
  - FIFO contents and Count are unaffected by a dropped write.
- UF:
  - Sets at the edge where Read && Empty.
  - Cleared by ClearUF or Clear/Reset; set wins over ClearUF.
  - DataOut holds its previous value on a refused read.
- FWFT=0:
  - DataOut is a register loaded with mem[ReadPtr] on rd_ok.
  - It is valid the cycle after Read and holds otherwise.
- FWFT=1:
  - DataOut = mem[ReadPtr] combinationally when !Empty, and 0 when Empty.
  - Read consumes the displayed word; the next word appears after the edge.
  - A word written into an empty FIFO appears on DataOut one cycle after the write edge.
- No state machine beyond the pointers and counter. Both pointers are ADDR_WIDTH bits; Count carries the extra bit that distinguishes Full from Empty.

Test Plan:
- Reset, then write 0x001..0x010 (16 words) -> Count=16, Full=1, AlmostFull asserted from Count=12. Read 16 with FWFT=0 -> DataOut 0x001..0x010 in order, each one cycle after Read; Empty=1 at end.
- Write 0x1AA while Full with no read -> OV=1, Count=16; subsequent reads return the original 16 words with no 0x1AA. Pulse ClearOV -> OV=0.
- While Full, assert Read and Write(0x155) in the same cycle -> Count stays 16, OV=0; 0x155 is read out as the 16th word after the remaining 15.
- Read while Empty -> UF=1, Count=0, DataOut unchanged. Same cycle Write 0x0F0 + Read on empty -> Count=1, UF=1.
- Pointer wrap: 40 interleaved write/read pairs at Count near 3 -> data order preserved across two pointer wraps; AlmostEmpty=1 throughout (Count<=4).
- FWFT=1: write 0x123 into empty -> DataOut=0x123 one cycle later with no Read. Assert Clear at Count=7 -> next cycle Count=0, Empty=1, OV=UF=0, DataOut=0. Assert Reset mid-burst -> same values immediately, without waiting for an edge.
